// File: rtl/pc_branch_unit_if.sv
// rtl/pc_branch_unit_if.sv - fetch/decode handshake bundle for pc_branch_unit
// Purpose: groups the instruction-side controls and the PC-side results of the
//   next-PC unit so the decode stage and the unit share one typed connection.
// Signals:
//   valid, stall, trap_ack           instruction present / hold / trap handler ready
//   op_type[1:0], funct_three[2:0]   00 seq, 01 branch, 10 jal, 11 jalr; branch condition
//   rs1, rs2, offset                 branch operands / jalr base, sign-extended immediate
//   pc, link                         registered PC, combinational PC+4
//   taken, trap, bad_target          redirect pulse, trap-wait flag, offending target
//   br_count, taken_count            retired / taken conditional branch counters
// Modports: master = decode side (drives instruction fields), slave = pc_branch_unit.
interface pc_branch_unit_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic            stall;
  logic [1:0]      op_type;
  logic [2:0]      funct_three;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] offset;
  logic            trap_ack;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] link;
  logic            taken;
  logic            trap;
  logic [XLEN-1:0] bad_target;
  logic [31:0]     br_count;
  logic [31:0]     taken_count;

  modport master (
    output valid, stall, op_type, funct_three, rs1, rs2, offset, trap_ack,
    input  pc, link, taken, trap, bad_target, br_count, taken_count
  );

  modport slave (
    input  valid, stall, op_type, funct_three, rs1, rs2, offset, trap_ack,
    output pc, link, taken, trap, bad_target, br_count, taken_count
  );
endinterface

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - RV32 next-PC generator, branch resolver and PC register
// Purpose: holds the architectural PC, resolves beq/bne/blt/bge/bltu/bgeu from raw
//   operands plus jal/jalr, and parks in a trap-wait state on a misaligned taken
//   target until the trap handler acknowledges.
// Ports:
//   clk_i   clock, all state updates on posedge
//   rst_i   synchronous active-high reset, overrides everything
//   bus     pc_branch_unit_if.slave (instruction controls in, PC/trap/counters out)
// Parameters: XLEN, RESET_VECTOR, TRAP_VECTOR, IALIGN (2 or 4).
// Optional feature: define PCBRANCH_PERF_EN to build the branch/taken counters;
//   without it br_count and taken_count are tied to zero.
module pc_branch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              IALIGN       = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pc_branch_unit_if.slave  bus
);

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_TRAP_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] OP_SEQ    = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_JAL    = 2'b10;
  localparam logic [1:0] OP_JALR   = 2'b11;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] bad_q, bad_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            cond_true;
  logic            is_taken;
  logic            misaligned;
  logic            update;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign jalr_sum = bus.rs1 + bus.offset;

  always_comb begin
    cond_true = 1'b0;
    unique case (bus.funct_three)
      3'b000:  cond_true = (bus.rs1 == bus.rs2);
      3'b001:  cond_true = (bus.rs1 != bus.rs2);
      3'b100:  cond_true = ($signed(bus.rs1) <  $signed(bus.rs2));
      3'b101:  cond_true = ($signed(bus.rs1) >= $signed(bus.rs2));
      3'b110:  cond_true = (bus.rs1 <  bus.rs2);
      3'b111:  cond_true = (bus.rs1 >= bus.rs2);
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    is_taken = 1'b0;
    target   = pc_q + bus.offset;
    unique case (bus.op_type)
      OP_SEQ:    is_taken = 1'b0;
      OP_BRANCH: is_taken = cond_true;
      OP_JAL:    is_taken = 1'b1;
      OP_JALR: begin
        is_taken = 1'b1;
        // jalr clears bit 0 before the alignment check
        target   = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default:   is_taken = 1'b0;
    endcase
  end

  // With IALIGN=2 only bit 0 matters; with 4, bits [1:0] must both be clear.
  assign misaligned = is_taken && ((IALIGN == 2) ? target[0] : (|target[1:0]));
  assign update     = (state_q == ST_RUN) && bus.valid && !bus.stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    trap_d  = trap_q;
    bad_d   = bad_q;
    unique case (state_q)
      ST_RUN: begin
        if (update) begin
          if (!is_taken) begin
            pc_d = pc_plus4;
          end else if (misaligned) begin
            trap_d  = 1'b1;
            bad_d   = target;
            state_d = ST_TRAP_WAIT;
          end else begin
            pc_d    = target;
            taken_d = 1'b1;
          end
        end
      end
      ST_TRAP_WAIT: begin
        // acknowledge is honoured even while stalled
        if (bus.trap_ack) begin
          pc_d    = TRAP_VECTOR;
          trap_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      taken_q <= 1'b0;
      trap_q  <= 1'b0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      trap_q  <= trap_d;
      bad_q   <= bad_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.link       = pc_plus4;
  assign bus.taken      = taken_q;
  assign bus.trap       = trap_q;
  assign bus.bad_target = bad_q;

`ifdef PCBRANCH_PERF_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] tk_cnt_q, tk_cnt_d;

  // A misaligned branch still retires (counts in br) but is not a taken redirect.
  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    if (update && (bus.op_type == OP_BRANCH)) begin
      br_cnt_d = br_cnt_q + 32'd1;
      if (is_taken && !misaligned) begin
        tk_cnt_d = tk_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  assign bus.br_count    = br_cnt_q;
  assign bus.taken_count = tk_cnt_q;
`else
  assign bus.br_count    = '0;
  assign bus.taken_count = '0;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - scoreboard bench for pc_branch_unit
module tb_pc_branch_unit;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_branch_unit_if #(.XLEN(32)) aif ();
  pc_branch_unit_if #(.XLEN(32)) bif ();

  pc_branch_unit #(.XLEN(32), .IALIGN(4)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (aif.slave)
  );

  pc_branch_unit #(.XLEN(32), .IALIGN(2)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif.slave)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] link;
    logic        taken;
    logic        trap;
    logic [31:0] bad;
    logic [31:0] br;
    logic [31:0] tk;
  } exp_a_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];

  int checks = 0;
  int errors = 0;
  int cnt_br = 0;
  int cnt_tk = 0;
  logic [31:0] b_exp_pc  = 32'h0;
  logic        b_exp_tk  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) begin
      exp_a_t e;
      e = qa.pop_front();
      chk("pc",          aif.pc,          e.pc);
      chk("link",        aif.link,        e.link);
      chk("taken",       32'(aif.taken),  32'(e.taken));
      chk("trap",        32'(aif.trap),   32'(e.trap));
      chk("bad_target",  aif.bad_target,  e.bad);
      chk("br_count",    aif.br_count,    e.br);
      chk("taken_count", aif.taken_count, e.tk);
    end
    if (qb.size() > 0) begin
      exp_b_t eb;
      eb = qb.pop_front();
      chk("ialign2_pc",    bif.pc,          eb.pc);
      chk("ialign2_taken", 32'(bif.taken),  32'(eb.taken));
      chk("ialign2_trap",  32'(bif.trap),   32'h0);
    end
  end

  task automatic step(input logic r, input logic v, input logic s, input logic [1:0] op,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] off, input logic ack, input logic [31:0] e_pc,
                      input logic e_tk, input logic e_trap, input logic [31:0] e_bad,
                      input int br_i, input int tk_i);
    exp_a_t e;
    rst              = r;
    aif.valid        = v;
    aif.stall        = s;
    aif.op_type      = op;
    aif.funct_three  = f3;
    aif.rs1          = a;
    aif.rs2          = b;
    aif.offset       = off;
    aif.trap_ack     = ack;
    if (r) begin
      cnt_br = 0;
      cnt_tk = 0;
    end else begin
      cnt_br += br_i;
      cnt_tk += tk_i;
    end
    e.pc    = e_pc;
    e.link  = e_pc + 32'd4;
    e.taken = e_tk;
    e.trap  = e_trap;
    e.bad   = e_bad;
`ifdef PCBRANCH_PERF_EN
    e.br    = 32'(cnt_br);
    e.tk    = 32'(cnt_tk);
`else
    e.br    = 32'h0;
    e.tk    = 32'h0;
`endif
    qa.push_back(e);
    qb.push_back('{pc: b_exp_pc, taken: b_exp_tk});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    aif.valid = 1'b0; aif.stall = 1'b0; aif.op_type = 2'b00; aif.funct_three = 3'b000;
    aif.rs1 = '0; aif.rs2 = '0; aif.offset = '0; aif.trap_ack = 1'b0;
    bif.valid = 1'b0; bif.stall = 1'b0; bif.op_type = 2'b00; bif.funct_three = 3'b000;
    bif.rs1 = '0; bif.rs2 = '0; bif.offset = '0; bif.trap_ack = 1'b0;
    @(negedge clk);

    // reset, then sequential step; IALIGN=2 unit takes jalr to 0x1002 alongside
    step(1, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    bif.valid = 1'b1; bif.op_type = 2'b11; bif.rs1 = 32'h1001; bif.offset = 32'h2;
    b_exp_pc = 32'h1002; b_exp_tk = 1'b1;
    step(0, 1, 0, 2'b00, 3'b000, 0, 0, 0, 0, 32'h4, 0, 0, 32'h0, 0, 0);
    bif.valid = 1'b0; b_exp_tk = 1'b0;
    // jal to 0x40, beq taken to 0x50, idle clears taken
    step(0, 1, 0, 2'b10, 3'b000, 0, 0, 32'h3C, 0, 32'h40, 1, 0, 32'h0, 0, 0);
    step(0, 1, 0, 2'b01, 3'b000, 5, 5, 32'h10, 0, 32'h50, 1, 0, 32'h0, 1, 1);
    step(0, 0, 0, 2'b01, 3'b000, 5, 5, 32'h10, 0, 32'h50, 0, 0, 32'h0, 0, 0);
    // back to 0x40, bne equal operands -> 0x44
    step(0, 1, 0, 2'b10, 3'b000, 0, 0, 32'hFFFFFFF0, 0, 32'h40, 1, 0, 32'h0, 0, 0);
    step(0, 1, 0, 2'b01, 3'b001, 5, 5, 32'h10, 0, 32'h44, 0, 0, 32'h0, 1, 0);
    // signed vs unsigned: blt taken, bltu not taken, bgeu taken
    step(0, 1, 0, 2'b01, 3'b100, 32'hFFFFFFFF, 1, 32'h8, 0, 32'h4C, 1, 0, 32'h0, 1, 1);
    step(0, 1, 0, 2'b01, 3'b110, 32'hFFFFFFFF, 1, 32'h8, 0, 32'h50, 0, 0, 32'h0, 1, 0);
    step(0, 1, 0, 2'b01, 3'b111, 32'hFFFFFFFF, 1, 32'h10, 0, 32'h60, 1, 0, 32'h0, 1, 1);
    // reserved funct_three 010 never taken
    step(0, 1, 0, 2'b01, 3'b010, 7, 7, 32'h10, 0, 32'h64, 0, 0, 32'h0, 1, 0);
    // stalled jal holds, then redirects
    step(0, 1, 1, 2'b10, 3'b000, 0, 0, 32'h20, 0, 32'h64, 0, 0, 32'h0, 0, 0);
    step(0, 1, 0, 2'b10, 3'b000, 0, 0, 32'h20, 0, 32'h84, 1, 0, 32'h0, 0, 0);
    // misaligned jalr traps; valid ignored in trap; ack under stall -> 0x100
    step(0, 1, 0, 2'b11, 3'b000, 32'h1001, 0, 32'h2, 0, 32'h84, 0, 1, 32'h1002, 0, 0);
    step(0, 1, 0, 2'b10, 3'b000, 0, 0, 32'h8, 0, 32'h84, 0, 1, 32'h1002, 0, 0);
    step(0, 0, 1, 2'b00, 3'b000, 0, 0, 0, 1, 32'h100, 0, 0, 32'h1002, 0, 0);
    // misaligned branch counts as retired but not taken
    step(0, 1, 0, 2'b01, 3'b000, 3, 3, 32'h6, 0, 32'h100, 0, 1, 32'h106, 1, 0);
    // reset during trap wait
    b_exp_pc = 32'h0;
    step(1, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    // trap_ack in RUN ignored
    step(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 1, 32'h0, 0, 0, 32'h0, 0, 0);
    // jalr to top of space, sequential wrap to zero
    step(0, 1, 0, 2'b11, 3'b000, 32'hFFFFFFF0, 0, 32'hC, 0, 32'hFFFFFFFC, 1, 0, 32'h0, 0, 0);
    step(0, 1, 0, 2'b00, 3'b000, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    // three branches, two taken
    step(0, 1, 0, 2'b01, 3'b000, 5, 5, 32'h8, 0, 32'h8, 1, 0, 32'h0, 1, 1);
    step(0, 1, 0, 2'b01, 3'b001, 5, 5, 32'h8, 0, 32'hC, 0, 0, 32'h0, 1, 0);
    step(0, 1, 0, 2'b01, 3'b101, 1, 32'hFFFFFFFF, 32'h4, 0, 32'h10, 1, 0, 32'h0, 1, 1);
    aif.valid = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drain_a", 32'(qa.size()), 32'h0);
    chk("scoreboard_drain_b", 32'(qb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
